// File: rtl/cpu_package.sv
// Shared CPU types: datapath width, ALU opcode/flag types and the ALU arbiter state encoding.
package CPU_package;

    localparam int DATA_WIDTH  = 8;
    localparam int ARB_NUM_REQ = 4;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_ADC,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } enum_alu_opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } struct_alu_flag_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } enum_arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin search: first requester after last_grant, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        // k runs 1..N so last_grant itself is considered last
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N);
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters; registered operands,
// held response, and a per-requester carry bit for chained multi-word arithmetic.
module alu_arbiter
    import CPU_package::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b,
    input  enum_alu_opcode_t [NUM_REQ-1:0]       req_opcode,
    input  logic [NUM_REQ-1:0]                   req_mode,
    input  logic [NUM_REQ-1:0]                   req_use_carry,
    output logic [DATA_WIDTH-1:0]                alu_a,
    output logic [DATA_WIDTH-1:0]                alu_b,
    output logic                                 alu_carry_in,
    output enum_alu_opcode_t                     alu_op,
    output logic                                 alu_mode_o,
    input  logic [DATA_WIDTH-1:0]                alu_result,
    input  struct_alu_flag_t                     alu_flag,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [IDX_W-1:0]                     rsp_id,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output struct_alu_flag_t                     rsp_flag,
    output logic                                 busy
);

    enum_arb_state_t     state_q, state_d;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                any_grant;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    id_q;
    logic [NUM_REQ-1:0]  carry_q;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_grant) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_carry_in <= 1'b0;
            alu_op       <= ALU_ADD;
            alu_mode_o   <= 1'b0;
            id_q         <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            carry_q      <= '0;
            rsp_data     <= '0;
            rsp_flag     <= '0;
        end else begin
            if (state_q == IDLE && any_grant) begin
                alu_a        <= req_a[grant_idx];
                alu_b        <= req_b[grant_idx];
                alu_op       <= req_opcode[grant_idx];
                alu_mode_o   <= req_mode[grant_idx];
                alu_carry_in <= req_use_carry[grant_idx] & carry_q[grant_idx];
                id_q         <= grant_idx;
                last_grant   <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_data <= alu_result;
                rsp_flag <= alu_flag;
                // logic ops must not disturb a carry chain in progress
                if (!alu_mode_o) begin
                    carry_q[id_q] <= alu_flag.carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to its ALU port.
module tb_alu_arbiter;
    import CPU_package::*;

    logic                       clk;
    logic                       rst_n;
    logic [3:0]                 req_valid;
    logic [3:0]                 req_ready;
    logic [3:0][7:0]            req_a;
    logic [3:0][7:0]            req_b;
    enum_alu_opcode_t [3:0]     req_opcode;
    logic [3:0]                 req_mode;
    logic [3:0]                 req_use_carry;
    logic [7:0]                 alu_a, alu_b;
    logic                       alu_carry_in;
    enum_alu_opcode_t           alu_op;
    logic                       alu_mode_o;
    logic [7:0]                 alu_result;
    struct_alu_flag_t           alu_flag;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [1:0]                 rsp_id;
    logic [7:0]                 rsp_data;
    struct_alu_flag_t           rsp_flag;
    logic                       busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_opcode    (req_opcode),
        .req_mode      (req_mode),
        .req_use_carry (req_use_carry),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry_in  (alu_carry_in),
        .alu_op        (alu_op),
        .alu_mode_o    (alu_mode_o),
        .alu_result    (alu_result),
        .alu_flag      (alu_flag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_flag      (rsp_flag),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] sum;
    always_comb begin
        sum = '0;
        case (alu_op)
            ALU_ADD: sum = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_ADC: sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
            ALU_SUB: sum = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_AND: sum = {1'b0, alu_a & alu_b};
            ALU_OR:  sum = {1'b0, alu_a | alu_b};
            ALU_XOR: sum = {1'b0, alu_a ^ alu_b};
            default: sum = '0;
        endcase
        alu_result        = sum[7:0];
        alu_flag.carry    = sum[8];
        alu_flag.zero     = (sum[7:0] == 8'd0);
        alu_flag.negative = sum[7];
        alu_flag.overflow = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one operation with rsp_ready held high and check the whole round trip.
    task automatic run_op(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                          input enum_alu_opcode_t op, input logic mode, input logic uc,
                          input logic exp_cin, input logic [7:0] exp_data, input logic exp_carry);
        int t;
        req_a[idx]         = a;
        req_b[idx]         = b;
        req_opcode[idx]    = op;
        req_mode[idx]      = mode;
        req_use_carry[idx] = uc;
        req_valid          = 4'b0001 << idx;
        #1;
        t = 0;
        while (!req_ready[idx] && t < 20) begin
            tick();
            t++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'(4'b0001 << idx));
        tick();
        req_valid = '0;
        chk({tag, " exec ready"}, 32'(req_ready), 32'd0);
        chk({tag, " carry_in"}, 32'(alu_carry_in), 32'(exp_cin));
        tick();
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rsp_id"}, 32'(rsp_id), 32'(idx));
        chk({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, " rsp_carry"}, 32'(rsp_flag.carry), 32'(exp_carry));
        tick();
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_a         = '0;
        req_b         = '0;
        req_opcode    = {ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD};
        req_mode      = '0;
        req_use_carry = '0;
        rsp_ready     = 1'b0;

        #12;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        do_reset();

        rsp_ready = 1'b1;
        run_op("single", 2, 8'd5, 8'd3, ALU_ADD, 1'b0, 1'b0, 1'b0, 8'd8, 1'b0);

        // all four valid, pointer reset so the order is 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i]      = 8'(10 * i + 1);
            req_b[i]      = 8'(i);
            req_opcode[i] = ALU_ADD;
        end
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr exec ready", 32'(req_ready), 32'd0);
            tick();
            chk("rr rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rr rsp_id", 32'(rsp_id), 32'(k % 4));
            chk("rr rsp_data", 32'(rsp_data), 32'(11 * (k % 4) + 1));
            tick();
        end
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        run_op("chain add", 1, 8'hFF, 8'h01, ALU_ADD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("chain other", 0, 8'h00, 8'h00, ALU_ADC, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_op("chain adc", 1, 8'h00, 8'h00, ALU_ADC, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0);

        run_op("logic pre", 3, 8'hFF, 8'h01, ALU_ADD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("logic and", 3, 8'hFF, 8'h0F, ALU_AND, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b0);
        run_op("logic post", 3, 8'h00, 8'h00, ALU_ADC, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0);

        // backpressure: hold the response while another requester waits
        rsp_ready         = 1'b0;
        req_a[2]          = 8'd7;
        req_b[2]          = 8'd9;
        req_opcode[2]     = ALU_ADD;
        req_mode[2]       = 1'b0;
        req_use_carry[2]  = 1'b0;
        req_valid         = 4'b0100;
        #1;
        chk("bp grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp rsp_data", 32'(rsp_data), 32'd16);
            chk("bp rsp_id", 32'(rsp_id), 32'd2);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp release busy", 32'(busy), 32'd0);
        chk("bp release grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();

        // reset mid-operation drops the response and clears the carry store
        run_op("rst pre", 1, 8'hFF, 8'h01, ALU_ADD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        req_a[2]   = 8'd4;
        req_b[2]   = 8'd4;
        req_valid  = 4'b0100;
        #1;
        chk("rst grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("rst exec busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rst first grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();
        run_op("rst carry", 1, 8'h00, 8'h00, ALU_ADC, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
